// File: rtl/pipe_pkg.sv
// pipe_pkg -- constants shared by the result FIFO and the upstream pipelining
// stage, plus a saturating accumulate helper used by the optional running sum.
//   DATA_W    : width of the F result (10)
//   SUM_W     : width of the running-sum output (16)
//   LAT_DEF   : default pipeline latency from operand issue to valid F (3)
//   DEPTH_DEF : default FIFO depth (8)
package pipe_pkg;

  localparam int DATA_W    = 10;
  localparam int SUM_W     = 16;
  localparam int LAT_DEF   = 3;
  localparam int DEPTH_DEF = 8;

  // acc + v, clamped to all-ones instead of wrapping.
  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0]  acc,
                                               input logic [DATA_W-1:0] v);
    logic [SUM_W:0] t;
    t = {1'b0, acc} + {{(SUM_W + 1 - DATA_W){1'b0}}, v};
    return t[SUM_W] ? {SUM_W{1'b1}} : t[SUM_W-1:0];
  endfunction

endpackage

// File: rtl/pipe_result_fifo_if.sv
// pipe_result_fifo_if -- output handshake of the result FIFO.
//   out_data  : head sample (FIFO -> consumer)
//   out_valid : out_data holds a valid sample (FIFO -> consumer)
//   out_ready : consumer accepts the head sample (consumer -> FIFO)
// Handshake: a sample transfers on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_valid and out_data
// hold steady until that transfer. out_ready carries no meaning while
// out_valid is low, and out_valid never depends combinationally on out_ready.
// Modports: master = FIFO side, slave = consumer side.
interface pipe_result_fifo_if;
  import pipe_pkg::*;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/pipe_valid_delay.sv
// pipe_valid_delay -- LAT-stage shift register that tracks issue_valid down the
// pipeline, so q rises in the cycle whose f_in belongs to that issue.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, empties every stage
//   d   : issue strobe
//   q   : strobe delayed by LAT cycles
module pipe_valid_delay #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [LAT-1:0] sr;

  generate
    if (LAT == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= d;
      end
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= {sr[LAT-2:0], d};
      end
    end
  endgenerate

  assign q = sr[LAT-1];

endmodule

// File: rtl/pipe_result_fifo.sv
// pipe_result_fifo -- captures the F result of a fixed-latency pipeline and
// buffers it in a DEPTH-entry FIFO for a ready/valid consumer.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   issue_valid  : operands presented to the pipeline this cycle
//   f_in         : F result, valid LAT cycles after its issue
//   res          : output handshake (out_data / out_valid / out_ready)
//   count        : occupancy, 0..DEPTH
//   full         : count == DEPTH
//   overflow     : sticky, a captured sample was dropped; clears only on rst
//   sum          : only with macro PIPE_RES_SUM_EN defined -- saturating total
//                  of accepted samples, updated the cycle after each push
module pipe_result_fifo
  import pipe_pkg::*;
#(
  parameter int LAT   = LAT_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [DATA_W-1:0]        f_in,
  pipe_result_fifo_if.master       res,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
`ifdef PIPE_RES_SUM_EN
  ,
  output logic [SUM_W-1:0]         sum
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic              cap;
  logic              push;
  logic              pop;
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [DATA_W-1:0] mem [DEPTH];

  pipe_valid_delay #(.LAT(LAT)) u_delay (
    .clk (clk),
    .rst (rst),
    .d   (issue_valid),
    .q   (cap)
  );

  // Output comes from registered state only; f_in never reaches out_data in
  // the same cycle. out_data reads 0 whenever the FIFO is empty.
  assign res.out_valid = (count != '0);
  assign res.out_data  = res.out_valid ? mem[rptr] : '0;
  assign full          = (count == FULL_CNT);

  assign pop  = res.out_valid && res.out_ready;
  // At full, a same-cycle pop frees the slot the new sample goes into.
  assign push = cap && (!full || pop);

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wptr] <= f_in;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (cap && full && !pop) overflow <= 1'b1;
    end
  end

`ifdef PIPE_RES_SUM_EN
  always_ff @(posedge clk) begin
    if (rst)       sum <= '0;
    else if (push) sum <= sat_add(sum, f_in);
  end
`endif

endmodule

// File: tb/tb_pipe_result_fifo.sv
// tb_pipe_result_fifo -- self-checking bench for pipe_result_fifo.
// A reference model keeps the FIFO as a queue of samples and the in-flight
// issues as a queue of issue cycles; every accepted sample is pushed into the
// expected queue, and a monitor pops and compares on each output transfer.
// Build with +define+PIPE_RES_SUM_EN to cover the running-sum output.
module tb_pipe_result_fifo;
  import pipe_pkg::*;

  localparam int LAT   = LAT_DEF;
  localparam int DEPTH = DEPTH_DEF;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [DATA_W-1:0] f_in;
  logic [CW-1:0]     count;
  logic              full;
  logic              overflow;
`ifdef PIPE_RES_SUM_EN
  logic [SUM_W-1:0]  sum;
`endif

  pipe_result_fifo_if rif ();

  pipe_result_fifo #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .f_in        (f_in),
    .res         (rif),
    .count       (count),
    .full        (full),
    .overflow    (overflow)
`ifdef PIPE_RES_SUM_EN
    ,
    .sum         (sum)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int                errors  = 0;
  int                checks  = 0;
  int                cyc     = 0;
  bit                started = 1'b0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] model_q[$];
  int                pend[$];
  logic [DATA_W-1:0] fsched[int];
  bit                model_ovf = 1'b0;
  int                model_sum = 0;
  int                popped    = 0;
  int                first_valid = -1;
  int                max_cnt   = 0;
  bit                watch     = 1'b0;
  bit                saw_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Inputs sampled at an edge belong to the cycle numbered cyc before it bumps.
  always @(posedge clk) begin : model
    bit m_cap, m_pop;
    if (rst) begin
      pend.delete();
      model_q.delete();
      exp_q.delete();
      model_ovf = 1'b0;
      model_sum = 0;
    end else begin
      m_pop = (model_q.size() > 0) && rif.out_ready;
      m_cap = (pend.size() > 0) && (pend[0] == cyc - LAT);
      if (m_cap) void'(pend.pop_front());
      if (issue_valid) pend.push_back(cyc);
      if (m_pop) void'(model_q.pop_front());
      if (m_cap) begin
        if (model_q.size() < DEPTH) begin
          model_q.push_back(f_in);
          exp_q.push_back(f_in);
          model_sum = (model_sum + int'(f_in) > 65535) ? 65535 : model_sum + int'(f_in);
        end else begin
          model_ovf = 1'b1;
        end
      end
    end
    cyc++;
    started = 1'b1;
  end

  // f_in carries the scheduled result in its capture cycle, noise otherwise.
  always @(posedge clk) begin
    #1;
    f_in = fsched.exists(cyc) ? fsched[cyc] : DATA_W'($urandom);
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (started) begin
      check("count", 32'(count), 32'(model_q.size()));
      check("out_valid", 32'(rif.out_valid), 32'(model_q.size() > 0));
      check("full", 32'(full), 32'(model_q.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(model_ovf));
`ifdef PIPE_RES_SUM_EN
      check("sum", 32'(sum), 32'(model_sum));
`endif
      if (!rst && rif.out_valid && rif.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 32'(1), 32'(0));
        else check("out_data", 32'(rif.out_data), 32'(exp_q.pop_front()));
        popped++;
      end
      if (rif.out_valid && first_valid < 0) first_valid = cyc;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (watch && rif.out_valid) saw_valid = 1'b1;
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit iv, input logic [DATA_W-1:0] v, input bit rdy, input bit r = 1'b0);
    rst           = r;
    issue_valid   = iv;
    rif.out_ready = rdy;
    if (iv) fsched[cyc + LAT] = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, '0, rdy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit rt;
    rst = 1'b1; issue_valid = 1'b0; rif.out_ready = 1'b0; f_in = '0;

    // Latency: reset in cycles 0-1, issues in cycles 5-7.
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b1);
    check("reset_out_data", 32'(rif.out_data), 32'(0));
    check("reset_out_valid", 32'(rif.out_valid), 32'(0));
    check("reset_count", 32'(count), 32'(0));
    check("reset_overflow", 32'(overflow), 32'(0));
    first_valid = -1; max_cnt = 0; popped = 0;
    idle(3, 1'b1);
    drive(1'b1, 10'd75, 1'b1);
    drive(1'b1, 10'd66, 1'b1);
    drive(1'b1, 10'd112, 1'b1);
    idle(8, 1'b1);
    check("latency_first_valid_cycle", 32'(first_valid), 32'(9));
    check("latency_max_count", 32'(max_cnt), 32'(1));
    check("latency_outputs", 32'(popped), 32'(3));

    // Full and overflow: nine issues into eight slots with no consumer.
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) drive(1'b1, DATA_W'(i), 1'b0);
    idle(LAT + 1, 1'b0);
    check("full_flag", 32'(full), 32'(1));
    check("full_count", 32'(count), 32'(8));
    check("overflow_set", 32'(overflow), 32'(1));
    popped = 0;
    idle(10, 1'b1);
    check("drain_outputs", 32'(popped), 32'(8));
    check("overflow_sticky", 32'(overflow), 32'(1));

    // Simultaneous push and pop while full.
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 11; i <= 18; i++) drive(1'b1, DATA_W'(i), 1'b0);
    idle(LAT + 1, 1'b0);
    drive(1'b1, 10'd19, 1'b0);
    idle(LAT - 1, 1'b0);
    drive(1'b0, '0, 1'b1);
    check("pushpop_full_count", 32'(count), 32'(8));
    check("pushpop_full_overflow", 32'(overflow), 32'(0));
    popped = 0;
    idle(10, 1'b1);
    check("pushpop_drain_outputs", 32'(popped), 32'(8));

    // Wrap-around: 20 samples, ready toggling every cycle.
    drive(1'b0, '0, 1'b0, 1'b1);
    popped = 0; rt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, DATA_W'($urandom), rt); rt = ~rt;
      drive(1'b0, '0, rt);                rt = ~rt;
    end
    for (int i = 0; i < 24; i++) begin
      drive(1'b0, '0, rt); rt = ~rt;
    end
    check("wrap_outputs", 32'(popped), 32'(20));
    check("wrap_overflow", 32'(overflow), 32'(0));

    // Reset one cycle after two issues discards them.
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b1, 10'd500, 1'b1);
    drive(1'b1, 10'd501, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b1);
    saw_valid = 1'b0; watch = 1'b1;
    idle(LAT + 3, 1'b1);
    watch = 1'b0;
    check("midreset_no_valid", 32'(saw_valid), 32'(0));
    check("midreset_count", 32'(count), 32'(0));

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, DATA_W'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 99) == 0);
    idle(DEPTH + LAT + 4, 1'b1);

`ifdef PIPE_RES_SUM_EN
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b1, 10'd75, 1'b1);
    drive(1'b1, 10'd66, 1'b1);
    drive(1'b1, 10'd112, 1'b1);
    idle(LAT + 2, 1'b1);
    check("sum_small", 32'(sum), 32'(253));
    for (int i = 0; i < 300; i++) drive(1'b1, 10'd1023, 1'b1);
    idle(LAT + 2, 1'b1);
    check("sum_saturated", 32'(sum), 32'(16'hFFFF));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
